// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types plus hazard-controller additions.
//   regbits_t      register-index width (5 bits)
//   hz_state_t     hazard control FSM states
//   shadow_slot_t  hazard-relevant fields of one in-flight instruction
//   REFILL_DEPTH   advancing cycles spent refilling after a flush
//   satInc         saturating 32-bit increment used by the perf counters
package cpu_types_pkg;

    localparam int REGBITS = 5;
    typedef logic [REGBITS-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_PEND = 2'd1,
        REFILL     = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic     valid;
        logic     memRead;
        regbits_t rd;
        logic     branch;
        logic     jump;
    } shadow_slot_t;

    localparam logic [1:0] REFILL_DEPTH = 2'd3;

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hz_shadow_slot.sv
// hz_shadow_slot: one shadow-pipeline register slot.
//   CLK, nRST  clock, asynchronous active-low reset
//   load       capture d on the next edge
//   zero       clear the slot on the next edge (wins over load)
//   d, q       slot contents in / out
module hz_shadow_slot
    import cpu_types_pkg::*;
(
    input  logic         CLK,
    input  logic         nRST,
    input  logic         load,
    input  logic         zero,
    input  shadow_slot_t d,
    output shadow_slot_t q
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= '0;
        end else if (zero) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: shadows the hazard-relevant fields of the EX and MEM
// instructions, feeds the HDU, and turns freeze / threeInstrFlush / cache
// status into per-stage latch enables and flushes.
//   CLK, nRST                       clock, asynchronous active-low reset
//   ihit, dmem_pend, dhit           fetch / data-memory status
//   id_*                            decode slot fields
//   freeze, three_flush             HDU requests
//   hdu_*                           HDU inputs (rs from decode, rd/memRead
//                                   from EX slot, branch/jump from MEM slot)
//   *_en, *_flush                   datapath latch enables and flushes
//   refilling                       post-flush refill in progress
// Optional build macro HAZARD_PERF_EN adds stall_cnt, flush_cnt and
// memstall_cnt (saturating 32-bit event counters).
//
// state      | meaning
// -----------+----------------------------------------------------------
// RUN        | normal flow
// FLUSH_PEND | flush requested during a memory stall, applied once it clears
// REFILL     | flush applied; pipeline refilling, freeze ignored
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  logic     dmem_pend,
    input  logic     dhit,
    input  logic     id_valid,
    input  regbits_t id_rs1,
    input  regbits_t id_rs2,
    input  regbits_t id_rd,
    input  logic     id_memRead,
    input  logic     id_branch,
    input  logic     id_jump,
    input  logic     freeze,
    input  logic     three_flush,
    output regbits_t hdu_rs1,
    output regbits_t hdu_rs2,
    output regbits_t hdu_rd,
    output logic     hdu_memRead,
    output logic     hdu_branch,
    output logic     hdu_jump,
    output logic     pc_en,
    output logic     ifid_en,
    output logic     idex_en,
    output logic     exmem_en,
    output logic     memwb_en,
    output logic     ifid_flush,
    output logic     idex_flush,
    output logic     exmem_flush,
    output logic     refilling
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] memstall_cnt
`endif
);

    hz_state_t    state, stateNext;
    logic [1:0]   refillCnt, refillCntNext;
    logic         memStall, flushReq, freezeEff, freezeApplied;
    shadow_slot_t exIn, exQ, memQ;

    assign memStall  = dmem_pend & ~dhit;
    assign flushReq  = three_flush | (state == FLUSH_PEND);
    // Slots are known clean after a flush, so a freeze during refill is stale.
    assign freezeEff = freeze & (state != REFILL);
    assign freezeApplied = nRST & ~memStall & ~flushReq & freezeEff;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            refillCnt <= 2'd0;
        end else begin
            state     <= stateNext;
            refillCnt <= refillCntNext;
        end
    end

    always_comb begin
        stateNext     = state;
        refillCntNext = refillCnt;
        unique case (state)
            RUN: begin
                if (three_flush) begin
                    if (memStall) begin
                        stateNext = FLUSH_PEND;
                    end else begin
                        stateNext     = REFILL;
                        refillCntNext = REFILL_DEPTH;
                    end
                end
            end
            FLUSH_PEND: begin
                if (!memStall) begin
                    stateNext     = REFILL;
                    refillCntNext = REFILL_DEPTH;
                end
            end
            REFILL: begin
                if (three_flush && memStall) begin
                    stateNext = FLUSH_PEND;
                end else if (three_flush) begin
                    refillCntNext = REFILL_DEPTH;
                end else if (!memStall) begin
                    // Leave on the advancing cycle that takes the count to 0.
                    if (refillCnt <= 2'd1) begin
                        stateNext     = RUN;
                        refillCntNext = 2'd0;
                    end else begin
                        refillCntNext = refillCnt - 2'd1;
                    end
                end
            end
            default: begin
                stateNext     = RUN;
                refillCntNext = 2'd0;
            end
        endcase
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!nRST || memStall) begin
            // everything held
        end else if (flushReq) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
        end else if (freezeEff) begin
            {idex_en, exmem_en, memwb_en} = 3'b111;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
            ifid_flush = 1'b1;
        end else begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        end
    end

    assign refilling = (state != RUN);

    assign exIn = '{valid: id_valid, memRead: id_memRead, rd: id_rd,
                    branch: id_branch, jump: id_jump};

    hz_shadow_slot uExSlot (
        .CLK  (CLK),
        .nRST (nRST),
        .load (idex_en),
        .zero (idex_flush),
        .d    (exIn),
        .q    (exQ)
    );

    hz_shadow_slot uMemSlot (
        .CLK  (CLK),
        .nRST (nRST),
        .load (exmem_en),
        .zero (exmem_flush),
        .d    (exQ),
        .q    (memQ)
    );

    assign hdu_rs1     = id_rs1;
    assign hdu_rs2     = id_rs2;
    assign hdu_rd      = exQ.rd;
    assign hdu_memRead = exQ.valid & exQ.memRead;
    assign hdu_branch  = memQ.valid & memQ.branch;
    assign hdu_jump    = memQ.valid & memQ.jump;

    // MEM-slot rd/memRead only travel along; nothing downstream needs them.
    logic unusedMemFields;
    assign unusedMemFields = ^{memQ.memRead, memQ.rd};

`ifdef HAZARD_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt    <= 32'd0;
            flush_cnt    <= 32'd0;
            memstall_cnt <= 32'd0;
        end else begin
            if (freezeApplied)         stall_cnt    <= satInc(stall_cnt);
            if (!memStall && flushReq) flush_cnt    <= satInc(flush_cnt);
            if (memStall)              memstall_cnt <= satInc(memstall_cnt);
        end
    end
`else
    logic unusedFreezeApplied;
    assign unusedFreezeApplied = freezeApplied;
`endif

endmodule
